// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one result bit per cycle, LSB first, IDLE -> RUN -> DONE.
// Optional subtract mode (A + ~B + 1) is built when SERIAL_ADD_SUB_EN is defined.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             i_sub,
`endif
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_nxt, sum_q;
  logic             c_q, carry_q;
  logic             a_bit, b_bit, p, g, s, c_next;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub_q;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (i_start) begin
        state_nxt = RUN;
        accept    = 1'b1;
      end
      RUN:  if (cnt == LAST) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-bit datapath: two half adders plus an OR for the carry.
  always_comb begin
    a_bit = a_q[cnt];
`ifdef SERIAL_ADD_SUB_EN
    b_bit = b_q[cnt] ^ sub_q;
`else
    b_bit = b_q[cnt];
`endif
    p       = a_bit ^ b_bit;
    g       = a_bit & b_bit;
    s       = p ^ c_q;
    c_next  = g | (p & c_q);
    res_nxt = res_q;
    res_nxt[cnt] = s;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
      cnt     <= '0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else if (accept) begin
      a_q   <= i_a;
      b_q   <= i_b;
      res_q <= '0;
      cnt   <= '0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q <= i_sub;
      c_q   <= i_sub;
`else
      c_q   <= 1'b0;
`endif
    end else if (state == RUN) begin
      res_q <= res_nxt;
      c_q   <= c_next;
      // Counter stops at the terminal count; the FSM leaves RUN on it.
      if (cnt != LAST) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        sum_q   <= res_nxt;
        carry_q <= c_next;
      end
    end
  end

  assign o_sum   = sum_q;
  assign o_carry = carry_q;
  assign o_busy  = (state == RUN);
  assign o_done  = (state == DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized self-checking bench for serial_add_ctrl (WIDTH=8) against an arithmetic model.
// Subtract vectors are applied only when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub = 1'b0;
`endif
  logic [W-1:0] sum;
  logic         carry, busy, done;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_done = -1;
  logic [W-1:0] exp_sum = '0;
  logic         exp_carry = 1'b0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_start   (start),
`ifdef SERIAL_ADD_SUB_EN
    .i_sub     (sub),
`endif
    .i_a       (a),
    .i_b       (b),
    .o_sum     (sum),
    .o_carry   (carry),
    .o_busy    (busy),
    .o_done    (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic do_sub);
    logic [W-1:0] ny;
    ny = ~y;
    if (do_sub) return {1'b0, x} + {1'b0, ny} + (W+1)'(1);
    else        return {1'b0, x} + {1'b0, y};
  endfunction

  // mode 0: quiet inputs; 1: random start/operand noise during RUN;
  // 2: interfering start with FF/FF in RUN cycle 3; 3: start held high.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic osub,
                        input int mode, input int abort_at, input bit b2b);
    logic [W:0] r;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    a = oa;
    b = ob;
`ifdef SERIAL_ADD_SUB_EN
    sub = osub;
`endif
    start = 1'b1;
    r = ref_add(oa, ob, osub);
    @(negedge clk);
    for (int k = 1; k <= W; k++) begin
      check("run_busy", busy, 1);
      check("run_done", done, 0);
      check("run_hold_sum", sum, exp_sum);
      check("run_hold_carry", carry, exp_carry);
      if (abort_at == k) begin
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_carry", carry, 0);
        exp_sum = '0;
        exp_carry = 1'b0;
        return;
      end
      case (mode)
        1: begin
          start = 1'($urandom_range(0, 1));
          a = W'($urandom);
          b = W'($urandom);
        end
        2: begin
          start = (k == 3);
          if (k == 3) begin
            a = 8'hFF;
            b = 8'hFF;
          end
        end
        3: start = 1'b1;
        default: start = 1'b0;
      endcase
      @(negedge clk);
    end
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("sum", sum, r[W-1:0]);
    check("carry", carry, r[W]);
    if (b2b && last_done >= 0) check("done_spacing", cyc - last_done, 10);
    last_done = cyc;
    exp_sum = r[W-1:0];
    exp_carry = r[W];
    start = (mode == 3);
  endtask

  initial begin
    #1;
    check("reset_sum", sum, 0);
    check("reset_carry", carry, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h03, 8'h05, 1'b0, 0, 0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 0, 0, 1'b0);
    run_op(8'hAA, 8'h55, 1'b0, 0, 0, 1'b0);
    run_op(8'h10, 8'h20, 1'b0, 2, 0, 1'b0);

    run_op(8'h0F, 8'h01, 1'b0, 0, 4, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check("in_reset_done", done, 0);
      check("in_reset_busy", busy, 0);
      check("in_reset_sum", sum, 0);
    end
    rst_n = 1'b1;
    run_op(8'h0F, 8'h01, 1'b0, 0, 0, 1'b0);

    last_done = -1;
    for (int i = 0; i < 3; i++) run_op(W'($urandom), W'($urandom), 1'b0, 3, 0, 1'b1);
    start = 1'b0;

    for (int i = 0; i < 20; i++) run_op(W'($urandom), W'($urandom), 1'b0, 1, 0, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    run_op(8'h07, 8'h05, 1'b1, 0, 0, 1'b0);
    run_op(8'h05, 8'h07, 1'b1, 0, 0, 1'b0);
    for (int i = 0; i < 10; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1, 0, 1'b0);
`endif

    @(negedge clk);
    start = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width in bits; legal range 2..32.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port i_clk, input, 1: sole clock; all state changes on its rising edge.
REQ-004 Port i_reset_n, input, 1: asynchronous active-low reset.
REQ-005 Port i_start, input, 1: operation request; sampled only in IDLE.
REQ-006 Port i_a, input, WIDTH: operand A; latched on start acceptance.
REQ-007 Port i_b, input, WIDTH: operand B; latched on start acceptance.
REQ-008 Port i_sub, input, 1: subtract request; latched on acceptance; present only when SERIAL_ADD_SUB_EN is defined.
REQ-009 Port o_sum, output, WIDTH: result register.
REQ-010 Port o_carry, output, 1: final carry-out of MSB stage.
REQ-011 Port o_busy, output, 1: high while bit-serial operation in progress.
REQ-012 Port o_done, output, 1: single-cycle completion pulse.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, DONE.
REQ-014 IDLE: when i_start=1 at a rising edge, latch i_a, i_b (and i_sub), clear bit counter, load carry register with 0 (or 1 for subtract), go to RUN; otherwise stay.
REQ-015 RUN: each cycle processes one bit, LSB first, index k = counter value 0..WIDTH-1.
REQ-016 Per-bit datapath SHALL be two cascaded half adders plus OR: s = a[k]^b'[k]^c, c_next = (a[k]&b'[k]) | ((a[k]^b'[k])&c); b' = b, or ~b when subtracting.
REQ-017 s written to internal shift/result register bit k; carry register updated to c_next each RUN cycle.
REQ-018 After bit WIDTH-1 processed, go to DONE; RUN lasts exactly WIDTH cycles.
REQ-019 DONE: o_sum and o_carry update from internal result and carry; o_done=1 for exactly this one cycle; next state IDLE unconditionally.
REQ-020 Timing: start sampled at edge t -> o_busy high cycles t+1..t+WIDTH -> o_done high in cycle t+WIDTH+1; minimum period between accepted starts WIDTH+2 cycles.
REQ-021 i_start in RUN or DONE SHALL be ignored (not queued); operand changes after acceptance SHALL have no effect.
REQ-022 o_sum/o_carry SHALL hold the last completed result until the next DONE; they SHALL not change during RUN.
REQ-023 Continuous i_start=1 SHALL yield back-to-back operations, one o_done pulse each.
REQ-024 Counter wrap-around SHALL not occur: counter width ceil(log2(WIDTH)), leaves RUN on terminal count.

Reset
REQ-025 i_reset_n=0 SHALL immediately force state IDLE, counter 0, carry 0, operand and result registers 0, o_sum=0, o_carry=0, o_busy=0, o_done=0.
REQ-026 Reset during RUN or DONE SHALL abort the operation with no o_done pulse; first start after release SHALL behave normally.

Configuration
REQ-027 Macro SERIAL_ADD_SUB_EN defined: i_sub exists; i_sub=1 computes A-B as A+~B+1; o_carry=1 means no borrow (A>=B unsigned).
REQ-028 Macro SERIAL_ADD_SUB_EN undefined: no i_sub port, no inversion logic; operation always A+B with carry-in 0.

Verification (WIDTH=8)
REQ-029 A=8'h03, B=8'h05, start pulse -> o_busy 8 cycles, o_done at start+9, o_sum=8'h08, o_carry=0.
REQ-030 A=8'hFF, B=8'h01 -> o_sum=8'h00, o_carry=1; A=8'hAA, B=8'h55 -> o_sum=8'hFF, o_carry=0.
REQ-031 Start A=8'h10, B=8'h20; at RUN cycle 3 pulse i_start with A=8'hFF, B=8'hFF -> single o_done, o_sum=8'h30.
REQ-032 Assert i_reset_n=0 at RUN cycle 4 of A=8'h0F, B=8'h01 -> all outputs 0 immediately, no o_done; after release A=8'h0F, B=8'h01 -> o_sum=8'h10.
REQ-033 i_start held high 3 operations -> o_done pulses spaced exactly 10 cycles apart.
REQ-034 With SERIAL_ADD_SUB_EN: A=8'h07, B=8'h05, i_sub=1 -> o_sum=8'h02, o_carry=1; A=8'h05, B=8'h07 -> o_sum=8'hFE, o_carry=0.
